dac_spi_multi: RTL and testbench



---
 rtl/dac_spi_pkg.sv | 40 ++++
 rtl/dac_spi_multi_tx.sv | 75 +++++++
 rtl/dac_spi_multi.sv | 156 +++++++++++++++
 tb/tb_dac_spi_multi.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// Shared definitions for the MCP49x2 multi-chip DAC SPI driver.
//   dac_state_t    : sequencer states (idle, shifting a frame, chip-select gap, LDAC pulse)
//   FRAME_BITS     : bits per SPI frame
//   HDR_*_BIT      : positions of the four header bits inside a frame
//   build_frame()  : assembles one 16-bit frame from channel select, config bits and data field
package dac_spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_LDAC  = 2'd3
   } dac_state_t;

   localparam int FRAME_BITS   = 16;
   localparam int FIELD_BITS   = 12;
   localparam int HDR_AB_BIT   = 15;
   localparam int HDR_BUF_BIT  = 14;
   localparam int HDR_GA_BIT   = 13;
   localparam int HDR_SHDN_BIT = 12;

   // field is the sample already left-justified into 12 bits.
   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic                  chan_b,
      input logic                  buffered,
      input logic                  gain_n,
      input logic                  shdn_n,
      input logic [FIELD_BITS-1:0] field
   );
      logic [FRAME_BITS-1:0] f;
      f                   = '0;
      f[HDR_AB_BIT]       = chan_b;
      f[HDR_BUF_BIT]      = buffered;
      f[HDR_GA_BIT]       = gain_n;
      f[HDR_SHDN_BIT]     = shdn_n;
      f[FIELD_BITS-1:0]   = field;
      return f;
   endfunction

endpackage

// File: rtl/dac_spi_multi_tx.sv
// spi_shift_tx: serialises one 16-bit word, SPI mode 0, MSB first.
//   clk, reset : clock, synchronous active-high reset
//   load       : one-cycle pulse; captures word and starts shifting on the next cycle
//   word       : frame to send
//   sclk, mosi : SPI clock (idles low) and data
//   done       : high during the final cycle of the last high phase
// Each bit is SCLK_DIV cycles low then SCLK_DIV cycles high; the register shifts
// at the end of a high phase so mosi only ever moves together with a falling sclk.
module spi_shift_tx
   import dac_spi_pkg::*;
#(
   parameter int SCLK_DIV = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [FRAME_BITS-1:0] word,
   output logic                  sclk,
   output logic                  mosi,
   output logic                  done
);

   localparam int             DW       = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [DW-1:0]  DIV_LAST = DW'(SCLK_DIV - 1);
   localparam int             BW       = $clog2(FRAME_BITS);
   localparam logic [BW-1:0]  BIT_LAST = BW'(FRAME_BITS - 1);

   logic [FRAME_BITS-1:0] shreg;
   logic [DW-1:0]         div_cnt;
   logic [BW-1:0]         bit_cnt;
   logic                  active;
   logic                  high;
   logic                  phase_end;

   assign phase_end = active && (div_cnt == DIV_LAST);
   assign done      = phase_end && high && (bit_cnt == BIT_LAST);
   assign sclk      = active && high;
   assign mosi      = active && shreg[FRAME_BITS-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '0;
         div_cnt <= '0;
         bit_cnt <= '0;
         active  <= 1'b0;
         high    <= 1'b0;
      end else if (load) begin
         shreg   <= word;
         div_cnt <= '0;
         bit_cnt <= '0;
         active  <= 1'b1;
         high    <= 1'b0;
      end else if (active) begin
         if (phase_end) begin
            div_cnt <= '0;
            if (!high) begin
               high <= 1'b1;
            end else begin
               high <= 1'b0;
               if (bit_cnt == BIT_LAST) begin
                  active  <= 1'b0;
                  bit_cnt <= '0;
                  shreg   <= '0;
               end else begin
                  bit_cnt <= bit_cnt + BW'(1);
                  shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
               end
            end
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/dac_spi_multi.sv
// dac_spi_multi: drives one or more MCP49x2 DACs on a shared SCLK/MOSI bus.
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : sample offered
//   in_ready   : idle; a sample is taken when in_valid && in_ready
//   in_data    : channel c at [c*DATA_BITS +: DATA_BITS]
//   in_mask    : per-channel send enable, captured with in_data
//   cs_n       : per-chip select, active low (channel c -> chip c/2)
//   sclk, mosi : SPI mode 0, MSB first
//   ldac_n     : shared latch pulse after the last frame, active low
//   busy       : !in_ready
// Handshake: in_ready is high only in IDLE; a sample transfers on a clock edge
// where in_valid && in_ready. An all-zero mask is consumed without any bus activity.
// Every frame is followed by a CS_GAP window, then the next enabled channel in
// ascending order, and after the last gap a single LDAC pulse (if enabled).
module dac_spi_multi
   import dac_spi_pkg::*;
#(
   parameter int CHANNELS    = 2,
   parameter int DATA_BITS   = 12,
   parameter int SCLK_DIV    = 1,
   parameter int CS_GAP      = 1,
   parameter int LDAC_CYCLES = 1,
   parameter bit BUFFERED    = 1'b1,
   parameter bit GAIN_N      = 1'b1,
   parameter bit SHDN_N      = 1'b1,
   localparam int NUM_CHIPS  = CHANNELS / 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [CHANNELS*DATA_BITS-1:0] in_data,
   input  logic [CHANNELS-1:0]           in_mask,
   output logic [NUM_CHIPS-1:0]          cs_n,
   output logic                          sclk,
   output logic                          mosi,
   output logic                          ldac_n,
   output logic                          busy
);

   localparam int            CIW       = $clog2(CHANNELS);
   localparam int            CNT_MAX   = (CS_GAP > LDAC_CYCLES) ? CS_GAP : LDAC_CYCLES;
   localparam int            CW        = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
   localparam logic [CW-1:0] LDAC_LAST = CW'((LDAC_CYCLES > 0) ? LDAC_CYCLES - 1 : 0);

   dac_state_t                  state, state_n;
   logic [CHANNELS*DATA_BITS-1:0] data_q;
   logic [CHANNELS-1:0]         pending;   // enabled channels not yet sent
   logic [CIW-1:0]              chan;      // channel currently on the bus
   logic [CW-1:0]               cnt;       // gap / LDAC width counter

   logic [CHANNELS-1:0]           sel_mask;
   logic [CHANNELS*DATA_BITS-1:0] sel_data;
   logic [CIW-1:0]                sel_idx;
   logic [DATA_BITS-1:0]          sel_sample;
   logic [FIELD_BITS-1:0]         field;
   logic [FRAME_BITS-1:0]         frame_word;
   logic [CHANNELS-1:0]           remaining;
   logic                          load;
   logic                          tx_done;

   // The next frame is chosen from the live inputs on the accept cycle and from
   // the captured sample during the gap, so the shifter loads on the same edge
   // that enters SHIFT.
   always_comb begin
      sel_mask = (state == ST_IDLE) ? in_mask : pending;
      sel_data = (state == ST_IDLE) ? in_data : data_q;
      sel_idx  = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (sel_mask[i]) sel_idx = CIW'(i);
      end
      sel_sample = sel_data[int'(sel_idx)*DATA_BITS +: DATA_BITS];
      field      = FIELD_BITS'(sel_sample) << (FIELD_BITS - DATA_BITS);
      frame_word = build_frame(sel_idx[0], BUFFERED, GAIN_N, SHDN_N, field);
      remaining  = sel_mask & ~(CHANNELS'(1) << sel_idx);
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (in_valid && (sel_mask != '0)) begin
               load    = 1'b1;
               state_n = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (tx_done) state_n = ST_GAP;
         end
         ST_GAP: begin
            if (cnt == GAP_LAST) begin
               if (pending != '0) begin
                  load    = 1'b1;
                  state_n = ST_SHIFT;
               end else if (LDAC_CYCLES > 0) begin
                  state_n = ST_LDAC;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         ST_LDAC: begin
            if (cnt == LDAC_LAST) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == ST_IDLE) && !reset;
      busy     = !in_ready;
      ldac_n   = (state != ST_LDAC);
      cs_n     = '1;
      for (int k = 0; k < NUM_CHIPS; k++) begin
         cs_n[k] = !((state == ST_SHIFT) && ((int'(chan) >> 1) == k));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         pending <= '0;
         chan    <= '0;
         data_q  <= '0;
      end else begin
         state <= state_n;
         // The counter restarts on every state change, so it reloads at its
         // terminal count instead of wrapping.
         if (state_n != state)
            cnt <= '0;
         else if (state == ST_GAP || state == ST_LDAC)
            cnt <= cnt + CW'(1);
         if (load) begin
            pending <= remaining;
            chan    <= sel_idx;
            if (state == ST_IDLE) data_q <= in_data;
         end
      end
   end

   spi_shift_tx #(
      .SCLK_DIV (SCLK_DIV)
   ) u_tx (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .word  (frame_word),
      .sclk  (sclk),
      .mosi  (mosi),
      .done  (tx_done)
   );

endmodule

// File: tb/tb_dac_spi_multi.sv
// Bench for dac_spi_multi with three configurations side by side:
//   u0: 2 channels, 12 bits, SCLK_DIV=1, CS_GAP=1, LDAC_CYCLES=1
//   u1: 2 channels,  8 bits, SCLK_DIV=3, CS_GAP=2, LDAC_CYCLES=0
//   u2: 4 channels, 12 bits, SCLK_DIV=1, CS_GAP=1, LDAC_CYCLES=2
module tb_dac_spi_multi;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUT signals ----------------
  logic        valid0, valid1, valid2;
  logic        ready0, ready1, ready2;
  logic        busy0, busy1, busy2;
  logic [23:0] data0;
  logic [15:0] data1;
  logic [47:0] data2;
  logic [1:0]  mask0, mask1;
  logic [3:0]  mask2;
  logic [0:0]  cs0, cs1;
  logic [1:0]  cs2;
  logic        sclk0, sclk1, sclk2;
  logic        mosi0, mosi1, mosi2;
  logic        ldac0, ldac1, ldac2;

  dac_spi_multi #(.CHANNELS(2), .DATA_BITS(12), .SCLK_DIV(1), .CS_GAP(1), .LDAC_CYCLES(1)) u0 (
    .clk(clk), .reset(reset), .in_valid(valid0), .in_ready(ready0), .in_data(data0),
    .in_mask(mask0), .cs_n(cs0), .sclk(sclk0), .mosi(mosi0), .ldac_n(ldac0), .busy(busy0));
  dac_spi_multi #(.CHANNELS(2), .DATA_BITS(8), .SCLK_DIV(3), .CS_GAP(2), .LDAC_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .in_valid(valid1), .in_ready(ready1), .in_data(data1),
    .in_mask(mask1), .cs_n(cs1), .sclk(sclk1), .mosi(mosi1), .ldac_n(ldac1), .busy(busy1));
  dac_spi_multi #(.CHANNELS(4), .DATA_BITS(12), .SCLK_DIV(1), .CS_GAP(1), .LDAC_CYCLES(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(valid2), .in_ready(ready2), .in_data(data2),
    .in_mask(mask2), .cs_n(cs2), .sclk(sclk2), .mosi(mosi2), .ldac_n(ldac2), .busy(busy2));

  // Uniform views; unused chip selects read as high.
  logic       sclk_w[3], mosi_w[3], ldac_w[3], ready_w[3], busy_w[3];
  logic [3:0] cs_w[3];
  assign sclk_w[0] = sclk0;  assign sclk_w[1] = sclk1;  assign sclk_w[2] = sclk2;
  assign mosi_w[0] = mosi0;  assign mosi_w[1] = mosi1;  assign mosi_w[2] = mosi2;
  assign ldac_w[0] = ldac0;  assign ldac_w[1] = ldac1;  assign ldac_w[2] = ldac2;
  assign ready_w[0] = ready0; assign ready_w[1] = ready1; assign ready_w[2] = ready2;
  assign busy_w[0] = busy0;  assign busy_w[1] = busy1;  assign busy_w[2] = busy2;
  assign cs_w[0] = {3'b111, cs0};
  assign cs_w[1] = {3'b111, cs1};
  assign cs_w[2] = {2'b11, cs2};

  function automatic int div_of(input int inst);
    return (inst == 1) ? 3 : 1;
  endfunction
  function automatic int ldac_of(input int inst);
    return (inst == 0) ? 1 : (inst == 1) ? 0 : 2;
  endfunction

  // ---------------- scoreboard ----------------
  // entry = {instance[1:0], cs_n[3:0], frame[15:0]}
  logic [21:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- bus monitor ----------------
  logic        prev_s[3], prev_m[3], prev_l[3];
  logic [3:0]  prev_cs[3], cs_at[3];
  logic [15:0] sh[3];
  int          bits[3], run[3], ldac_len[3], ldac_pulses[3], rises[3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      prev_s[i] = 0; prev_m[i] = 0; prev_l[i] = 1; prev_cs[i] = 4'hF; cs_at[i] = 4'hF;
      sh[i] = '0; bits[i] = 0; run[i] = 0; ldac_len[i] = 0; ldac_pulses[i] = 0; rises[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        logic s, m, l;
        logic [3:0] cs;
        logic [21:0] e;
        s = sclk_w[i]; m = mosi_w[i]; l = ldac_w[i]; cs = cs_w[i];
        check("busy_vs_ready", busy_w[i], !ready_w[i]);
        if (cs != 4'hF) begin
          check("one_cs_low", $countones(~cs), 1);
          if (prev_cs[i] == 4'hF) run[i] = 1;
          else if (s != prev_s[i]) begin
            check("sclk_phase_len", run[i], div_of(i));
            run[i] = 1;
          end else run[i]++;
        end
        if (s && !prev_s[i]) begin
          rises[i]++;
          check("mosi_stable_at_rise", m, prev_m[i]);
          sh[i] = {sh[i][14:0], m};
          cs_at[i] = cs;
          bits[i]++;
          if (bits[i] == 16) begin
            bits[i] = 0;
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL frame_unexpected actual=%0h required=none", {2'(i), cs_at[i], sh[i]});
            end else begin
              e = exp_q.pop_front();
              check("frame", {2'(i), cs_at[i], sh[i]}, e);
            end
          end
        end
        if (cs == 4'hF) bits[i] = 0;
        if (!l) begin
          check("ldac_cs_overlap", cs, 4'hF);
          ldac_len[i]++;
          if (prev_l[i]) ldac_pulses[i]++;
        end else if (!prev_l[i]) begin
          check("ldac_width", ldac_len[i], ldac_of(i));
          ldac_len[i] = 0;
        end
        prev_s[i] = s; prev_m[i] = m; prev_l[i] = l; prev_cs[i] = cs;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input int inst, input logic v, input logic [3:0] mask, input logic [47:0] data);
    case (inst)
      0: begin valid0 = v; mask0 = mask[1:0]; data0 = data[23:0]; end
      1: begin valid1 = v; mask1 = mask[1:0]; data1 = data[15:0]; end
      default: begin valid2 = v; mask2 = mask; data2 = data; end
    endcase
  endtask

  task automatic clear_counts(input int inst);
    ldac_pulses[inst] = 0;
    rises[inst] = 0;
  endtask

  // Offers one sample, drops valid after the accept edge, and counts in_ready-low cycles.
  task automatic do_send(input int inst, input logic [3:0] mask, input logic [47:0] data,
                         output int busy_cycles);
    @(posedge clk); #1;
    check("ready_before_send", ready_w[inst], 1'b1);
    set_inputs(inst, 1'b1, mask, data);
    @(posedge clk); #1;
    set_inputs(inst, 1'b0, mask, data);
    busy_cycles = 0;
    while (!ready_w[inst] && busy_cycles < 2000) begin
      busy_cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_checks(input int inst, input int busy_got, input int busy_exp,
                               input int nfr, input int ldac_exp);
    repeat (2) @(negedge clk);
    check("busy_cycles", busy_got, busy_exp);
    check("ldac_pulses", ldac_pulses[inst], ldac_exp);
    check("sclk_rises", rises[inst], 16 * nfr);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [1:0]       inst;
    logic [3:0]       mask;
    logic [47:0]      data;
    logic [2:0]       nfr;
    logic [3:0][15:0] fr;
    logic [3:0][3:0]  cs;
    logic [15:0]      busy;
    logic [1:0]       ldac;
  } vec_t;

  function automatic vec_t mk(input int inst, input logic [3:0] mask, input logic [47:0] data,
                              input int nfr,
                              input logic [15:0] f0, input logic [15:0] f1,
                              input logic [15:0] f2, input logic [15:0] f3,
                              input logic [3:0] c0, input logic [3:0] c1,
                              input logic [3:0] c2, input logic [3:0] c3,
                              input int busy, input int ldac);
    vec_t v;
    v.inst = 2'(inst); v.mask = mask; v.data = data; v.nfr = 3'(nfr);
    v.fr[0] = f0; v.fr[1] = f1; v.fr[2] = f2; v.fr[3] = f3;
    v.cs[0] = c0; v.cs[1] = c1; v.cs[2] = c2; v.cs[3] = c3;
    v.busy = 16'(busy); v.ldac = 2'(ldac);
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    int bc, n;
    logic [3:0]  rmask;
    logic [47:0] rdata;
    int          nfr;

    vecs[0] = mk(0, 4'b0011, 48'h123ABC, 2, 16'h7ABC, 16'hF123, 0, 0, 4'b1110, 4'b1110, 0, 0, 67, 1);
    vecs[1] = mk(0, 4'b0010, 48'h800555, 1, 16'hF800, 0, 0, 0, 4'b1110, 0, 0, 0, 34, 1);
    vecs[2] = mk(0, 4'b0000, 48'h123ABC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk(0, 4'b0001, 48'h000FFF, 1, 16'h7FFF, 0, 0, 0, 4'b1110, 0, 0, 0, 34, 1);
    vecs[4] = mk(0, 4'b0011, 48'hFFF000, 2, 16'h7000, 16'hFFFF, 0, 0, 4'b1110, 4'b1110, 0, 0, 67, 1);
    vecs[5] = mk(1, 4'b0001, 48'h005A, 1, 16'h75A0, 0, 0, 0, 4'b1110, 0, 0, 0, 98, 0);
    vecs[6] = mk(1, 4'b0011, 48'hFF01, 2, 16'h7010, 16'hFFF0, 0, 0, 4'b1110, 4'b1110, 0, 0, 196, 0);
    vecs[7] = mk(2, 4'b1111, 48'h300200100000, 4, 16'h7000, 16'hF100, 16'h7200, 16'hF300,
                 4'b1110, 4'b1110, 4'b1101, 4'b1101, 134, 1);
    vecs[8] = mk(2, 4'b1010, 48'hABCDEF123456, 2, 16'hF123, 16'hFABC, 0, 0, 4'b1110, 4'b1101, 0, 0, 68, 1);
    vecs[9] = mk(2, 4'b0100, 48'h0007E5000000, 1, 16'h77E5, 0, 0, 0, 4'b1101, 0, 0, 0, 35, 1);

    // ---- reset state ----
    reset = 1'b1;
    for (int i = 0; i < 3; i++) set_inputs(i, 1'b0, 4'h0, 48'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", cs_w[2], 4'hF);
    check("rst_sclk", sclk0, 1'b0);
    check("rst_mosi", mosi0, 1'b0);
    check("rst_ldac_n", ldac0, 1'b1);
    check("rst_in_ready", ready0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", ready2, 1'b1);

    // ---- table vectors ----
    for (int i = 0; i < 10; i++) begin
      for (int f = 0; f < int'(vecs[i].nfr); f++)
        exp_q.push_back({vecs[i].inst, vecs[i].cs[f], vecs[i].fr[f]});
      clear_counts(int'(vecs[i].inst));
      do_send(int'(vecs[i].inst), vecs[i].mask, vecs[i].data, bc);
      finish_checks(int'(vecs[i].inst), bc, int'(vecs[i].busy), int'(vecs[i].nfr), int'(vecs[i].ldac));
    end

    // ---- random samples on the 4-channel instance ----
    for (int r = 0; r < 4; r++) begin
      rmask = 4'($urandom_range(1, 15));
      rdata = {16'($urandom), 32'($urandom)};
      nfr = 0;
      for (int c = 0; c < 4; c++) begin
        if (rmask[c]) begin
          logic [3:0] cexp;
          logic [11:0] d;
          cexp = ~(4'b0001 << (c / 2));
          d = rdata[c*12 +: 12];
          exp_q.push_back({2'd2, cexp, (c % 2 == 1) ? 1'b1 : 1'b0, 3'b111, d});
          nfr++;
        end
      end
      clear_counts(2);
      do_send(2, rmask, rdata, bc);
      finish_checks(2, bc, nfr * 33 + 2, nfr, 1);
    end

    // ---- reset during bit 7 of the first frame ----
    clear_counts(0);
    @(posedge clk); #1;
    set_inputs(0, 1'b1, 4'b0011, 48'h123ABC);
    @(posedge clk); #1;
    set_inputs(0, 1'b0, 4'b0011, 48'h123ABC);
    repeat (14) begin @(posedge clk); #1; end
    check("abort_cs_low_before", cs0, 1'b0);
    check("abort_sclk_low_phase", sclk0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_cs_n", cs0, 1'b1);
    check("abort_sclk", sclk0, 1'b0);
    check("abort_mosi", mosi0, 1'b0);
    check("abort_ldac_n", ldac0, 1'b1);
    check("abort_ready_in_reset", ready0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_ready_returns", ready0, 1'b1);
    repeat (80) @(posedge clk);
    #1;
    check("abort_no_ldac", ldac_pulses[0], 0);
    check("abort_rises", rises[0], 7);
    check("abort_queue", exp_q.size(), 0);

    // ---- in_valid held with changing data while busy ----
    clear_counts(0);
    exp_q.push_back({2'd0, 4'b1110, 16'h7321});
    exp_q.push_back({2'd0, 4'b1110, 16'hF654});
    exp_q.push_back({2'd0, 4'b1110, 16'h70F0});
    @(posedge clk); #1;
    set_inputs(0, 1'b1, 4'b0011, 48'h654321);
    @(posedge clk); #1;
    n = 0;
    while (!ready0 && n < 2000) begin
      set_inputs(0, 1'b1, 4'($urandom_range(0, 3)), 48'($urandom));
      n++;
      @(posedge clk); #1;
    end
    check("hold_busy_cycles", n, 67);
    set_inputs(0, 1'b1, 4'b0001, 48'h0000F0);
    @(posedge clk); #1;
    check("hold_next_accepted", ready0, 1'b0);
    set_inputs(0, 1'b0, 4'b0001, 48'h0000F0);
    bc = 1;
    while (!ready0 && bc < 2000) begin
      @(posedge clk); #1;
      if (!ready0) bc++;
    end
    finish_checks(0, bc, 34, 3, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
